// File: rtl/display_timings_pkg.sv
// Shared types, presets and config checks for the programmable display timing generator.
package display_timings_pkg;

    localparam int CORDW = 16;
    localparam int FW    = CORDW - 1;

    typedef struct packed {
        logic [FW-1:0] h_res;
        logic [FW-1:0] h_fp;
        logic [FW-1:0] h_sync;
        logic [FW-1:0] h_bp;
        logic [FW-1:0] v_res;
        logic [FW-1:0] v_fp;
        logic [FW-1:0] v_sync;
        logic [FW-1:0] v_bp;
        logic          h_pol;
        logic          v_pol;
    } timing_cfg_t;

    localparam timing_cfg_t TIMING_640x480 = '{
        h_res: 15'd640,  h_fp: 15'd16,  h_sync: 15'd96, h_bp: 15'd48,
        v_res: 15'd480,  v_fp: 15'd10,  v_sync: 15'd2,  v_bp: 15'd33,
        h_pol: 1'b0,     v_pol: 1'b0
    };

    localparam timing_cfg_t TIMING_1280x720 = '{
        h_res: 15'd1280, h_fp: 15'd110, h_sync: 15'd40, h_bp: 15'd220,
        v_res: 15'd720,  v_fp: 15'd5,   v_sync: 15'd5,  v_bp: 15'd20,
        h_pol: 1'b1,     v_pol: 1'b1
    };

    // The blanking total must fit the unsigned field width so its negation fits signed CORDW.
    function automatic logic blank_fits(input logic [FW-1:0] fp, input logic [FW-1:0] sync,
                                        input logic [FW-1:0] bp);
        logic [FW+1:0] sum_s;
        sum_s = {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
        return (sum_s[FW+1:FW] == 2'b00);
    endfunction

    function automatic logic cfg_valid(input timing_cfg_t c);
        return (c.h_res  != {FW{1'b0}}) && (c.v_res  != {FW{1'b0}}) &&
               (c.h_sync != {FW{1'b0}}) && (c.v_sync != {FW{1'b0}}) &&
               blank_fits(c.h_fp, c.h_sync, c.h_bp) &&
               blank_fits(c.v_fp, c.v_sync, c.v_bp);
    endfunction

    // First blanking position of an axis: -(fp+sync+bp), fields zero-extended first.
    function automatic logic signed [CORDW-1:0] axis_sta(input logic [FW-1:0] fp,
                                                         input logic [FW-1:0] sync,
                                                         input logic [FW-1:0] bp);
        logic [CORDW-1:0] sum_s;
        sum_s = {1'b0, fp} + {1'b0, sync} + {1'b0, bp};
        return -signed'(sum_s);
    endfunction

endpackage

// File: rtl/display_timings_prog_axis.sv
// One beam-position axis: counts STA..res-1, reports its wrap and decodes sync for the next position.
module timing_axis import display_timings_pkg::*; #(
    parameter logic signed [CORDW-1:0] RST_STA = -16'sd160,
    parameter logic                    RST_POL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    en,
    input  logic [FW-1:0]           cur_res,
    input  logic [FW-1:0]           nxt_fp,
    input  logic [FW-1:0]           nxt_sync,
    input  logic [FW-1:0]           nxt_bp,
    input  logic                    nxt_pol,
    output logic signed [CORDW-1:0] pos,
    output logic signed [CORDW-1:0] pos_nxt,
    output logic                    at_sta_nxt,
    output logic                    wrap,
    output logic                    sync_out
);

    localparam logic signed [CORDW-1:0] ONE = {{(CORDW-1){1'b0}}, 1'b1};

    logic signed [CORDW-1:0] pos_r;
    logic signed [CORDW-1:0] end_s;
    logic signed [CORDW-1:0] sta_s;
    logic signed [CORDW-1:0] ss_s;
    logic signed [CORDW-1:0] se_s;
    logic                    in_sync_s;
    logic                    sync_r;

    // End is decided by the active config; STA and sync windows by the config in force next cycle.
    assign end_s      = signed'({1'b0, cur_res}) - ONE;
    assign wrap       = en && (pos_r == end_s);
    assign sta_s      = axis_sta(nxt_fp, nxt_sync, nxt_bp);
    assign ss_s       = sta_s + signed'({1'b0, nxt_fp});
    assign se_s       = ss_s + signed'({1'b0, nxt_sync});
    assign at_sta_nxt = (pos_nxt == sta_s);
    assign in_sync_s  = (pos_nxt >= ss_s) && (pos_nxt < se_s);

    // Next position: restart and wrap both land on STA.
    always_comb begin
        pos_nxt = pos_r;
        if (restart || wrap) begin
            pos_nxt = sta_s;
        end else if (en) begin
            pos_nxt = pos_r + ONE;
        end else begin
            pos_nxt = pos_r;
        end
    end

    // Position counter and polarity-adjusted sync register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r  <= RST_STA;
            sync_r <= ~RST_POL;
        end else begin
            pos_r  <= pos_nxt;
            sync_r <= nxt_pol ? in_sync_s : ~in_sync_s;
        end
    end

    assign pos      = pos_r;
    assign sync_out = sync_r;

endmodule

// File: rtl/display_timings_prog.sv
// Runtime-programmable display timing generator; new configs are staged and applied on a frame boundary.
module display_timings_prog #(
    parameter int   CORDW    = 16,
    parameter int   D_H_RES  = 640,
    parameter int   D_H_FP   = 16,
    parameter int   D_H_SYNC = 96,
    parameter int   D_H_BP   = 48,
    parameter int   D_V_RES  = 480,
    parameter int   D_V_FP   = 10,
    parameter int   D_V_SYNC = 2,
    parameter int   D_V_BP   = 33,
    parameter logic D_H_POL  = 1'b0,
    parameter logic D_V_POL  = 1'b0
) (
    input  logic                    i_pix_clk,
    input  logic                    i_rst_n,
    input  logic                    i_restart,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [CORDW-2:0]        i_cfg_h_res,
    input  logic [CORDW-2:0]        i_cfg_h_fp,
    input  logic [CORDW-2:0]        i_cfg_h_sync,
    input  logic [CORDW-2:0]        i_cfg_h_bp,
    input  logic [CORDW-2:0]        i_cfg_v_res,
    input  logic [CORDW-2:0]        i_cfg_v_fp,
    input  logic [CORDW-2:0]        i_cfg_v_sync,
    input  logic [CORDW-2:0]        i_cfg_v_bp,
    input  logic                    i_cfg_h_pol,
    input  logic                    i_cfg_v_pol,
    output logic                    o_cfg_pending,
    output logic                    o_cfg_err,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_de,
    output logic                    o_frame,
    output logic                    o_line,
    output logic signed [CORDW-1:0] o_sx,
    output logic signed [CORDW-1:0] o_sy
);
    import display_timings_pkg::*;

    localparam timing_cfg_t DEF_CFG = '{
        h_res: FW'(D_H_RES), h_fp: FW'(D_H_FP), h_sync: FW'(D_H_SYNC), h_bp: FW'(D_H_BP),
        v_res: FW'(D_V_RES), v_fp: FW'(D_V_FP), v_sync: FW'(D_V_SYNC), v_bp: FW'(D_V_BP),
        h_pol: D_H_POL,      v_pol: D_V_POL
    };

    timing_cfg_t act_r, shd_r, cfg_in_s, cfg_nxt_s, shd_nxt_s;
    logic        pending_r, pending_nxt_s, err_r, err_nxt_s;
    logic        accept_s, apply_s;
    logic        h_wrap_s, v_wrap_s, h_at_sta_s, v_at_sta_s;
    logic signed [CORDW-1:0] h_pos_nxt_s, v_pos_nxt_s;
    logic        de_r, frame_r, line_r;

    assign cfg_in_s = '{
        h_res: i_cfg_h_res, h_fp: i_cfg_h_fp, h_sync: i_cfg_h_sync, h_bp: i_cfg_h_bp,
        v_res: i_cfg_v_res, v_fp: i_cfg_v_fp, v_sync: i_cfg_v_sync, v_bp: i_cfg_v_bp,
        h_pol: i_cfg_h_pol, v_pol: i_cfg_v_pol
    };

    // Restart blocks the handshake and applies any staged config together with the counter jump.
    assign o_cfg_ready = ~pending_r & ~i_restart;
    assign accept_s    = i_cfg_valid & o_cfg_ready;
    assign apply_s     = pending_r & (i_restart | v_wrap_s);
    assign cfg_nxt_s   = apply_s ? shd_r : act_r;

    // Handshake, apply and error decisions for the next cycle.
    always_comb begin
        shd_nxt_s     = shd_r;
        pending_nxt_s = pending_r;
        err_nxt_s     = 1'b0;
        if (apply_s) begin
            pending_nxt_s = 1'b0;
        end else if (accept_s) begin
            if (cfg_valid(cfg_in_s)) begin
                shd_nxt_s     = cfg_in_s;
                pending_nxt_s = 1'b1;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Active/shadow config and handshake status registers.
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_r     <= DEF_CFG;
            shd_r     <= DEF_CFG;
            pending_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            act_r     <= cfg_nxt_s;
            shd_r     <= shd_nxt_s;
            pending_r <= pending_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    timing_axis #(
        .RST_STA (axis_sta(FW'(D_H_FP), FW'(D_H_SYNC), FW'(D_H_BP))),
        .RST_POL (D_H_POL)
    ) u_h_axis (
        .clk        (i_pix_clk),
        .rst_n      (i_rst_n),
        .restart    (i_restart),
        .en         (1'b1),
        .cur_res    (act_r.h_res),
        .nxt_fp     (cfg_nxt_s.h_fp),
        .nxt_sync   (cfg_nxt_s.h_sync),
        .nxt_bp     (cfg_nxt_s.h_bp),
        .nxt_pol    (cfg_nxt_s.h_pol),
        .pos        (o_sx),
        .pos_nxt    (h_pos_nxt_s),
        .at_sta_nxt (h_at_sta_s),
        .wrap       (h_wrap_s),
        .sync_out   (o_hs)
    );

    timing_axis #(
        .RST_STA (axis_sta(FW'(D_V_FP), FW'(D_V_SYNC), FW'(D_V_BP))),
        .RST_POL (D_V_POL)
    ) u_v_axis (
        .clk        (i_pix_clk),
        .rst_n      (i_rst_n),
        .restart    (i_restart),
        .en         (h_wrap_s),
        .cur_res    (act_r.v_res),
        .nxt_fp     (cfg_nxt_s.v_fp),
        .nxt_sync   (cfg_nxt_s.v_sync),
        .nxt_bp     (cfg_nxt_s.v_bp),
        .nxt_pol    (cfg_nxt_s.v_pol),
        .pos        (o_sy),
        .pos_nxt    (v_pos_nxt_s),
        .at_sta_nxt (v_at_sta_s),
        .wrap       (v_wrap_s),
        .sync_out   (o_vs)
    );

    // Beam flags registered from the next-state positions so they line up with o_sx/o_sy.
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_r    <= 1'b0;
            frame_r <= 1'b1;
            line_r  <= 1'b1;
        end else begin
            de_r    <= ~h_pos_nxt_s[CORDW-1] & ~v_pos_nxt_s[CORDW-1];
            frame_r <= h_at_sta_s & v_at_sta_s;
            line_r  <= h_at_sta_s;
        end
    end

    assign o_cfg_pending = pending_r;
    assign o_cfg_err     = err_r;
    assign o_de          = de_r;
    assign o_frame       = frame_r;
    assign o_line        = line_r;

endmodule

// File: tb/tb_display_timings_prog.sv
// Directed bench for display_timings_prog: reset, rejects, staged apply, restart, wrap-cycle handshake, async reset.
module tb_display_timings_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [14:0] h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp;
    logic        h_pol, v_pol;
    logic        ready, pending, err, hs, vs, de, frame, line;
    logic signed [15:0] sx, sy;

    int total = 0;
    int bad   = 0;
    int n_frame, n_line, n_de, n_hs, n_vs_low, min_sx, max_sx;

    display_timings_prog dut (
        .i_pix_clk     (clk),
        .i_rst_n       (rst_n),
        .i_restart     (restart),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (ready),
        .i_cfg_h_res   (h_res),
        .i_cfg_h_fp    (h_fp),
        .i_cfg_h_sync  (h_sync),
        .i_cfg_h_bp    (h_bp),
        .i_cfg_v_res   (v_res),
        .i_cfg_v_fp    (v_fp),
        .i_cfg_v_sync  (v_sync),
        .i_cfg_v_bp    (v_bp),
        .i_cfg_h_pol   (h_pol),
        .i_cfg_v_pol   (v_pol),
        .o_cfg_pending (pending),
        .o_cfg_err     (err),
        .o_hs          (hs),
        .o_vs          (vs),
        .o_de          (de),
        .o_frame       (frame),
        .o_line        (line),
        .o_sx          (sx),
        .o_sy          (sy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int hr, input int hf, input int hsy, input int hb,
                           input int vr, input int vf, input int vsy, input int vb,
                           input logic hp, input logic vp);
        h_res = 15'(hr); h_fp = 15'(hf); h_sync = 15'(hsy); h_bp = 15'(hb);
        v_res = 15'(vr); v_fp = 15'(vf); v_sync = 15'(vsy); v_bp = 15'(vb);
        h_pol = hp;      v_pol = vp;
    endtask

    initial begin
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        step(2);
        chk("rst_sx", sx, -160);
        chk("rst_sy", sy, -45);
        chk("rst_frame", frame, 1);
        chk("rst_line", line, 1);
        chk("rst_de", de, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_ready", ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        // Default 640x480: hsync low from sx=-144 to -49
        step(15);
        chk("def_sx15", sx, -145);
        chk("def_hs_before", hs, 1);
        chk("def_line_mid", line, 0);
        step(1);
        chk("def_hs_start", hs, 0);

        // Rejected configs: zero h_res, then blanking overflow
        set_cfg(0, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk("err_hres0_pulse", err, 1);
        chk("err_hres0_pending", pending, 0);
        chk("err_hres0_ready", ready, 1);
        step(1);
        chk("err_hres0_clear", err, 0);
        set_cfg(640, 32767, 1, 0, 480, 10, 2, 33, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk("err_ovf_pulse", err, 1);
        chk("err_ovf_pending", pending, 0);
        step(1);
        chk("err_ovf_clear", err, 0);
        chk("timing_unchanged_sx", sx, -140);

        // Stage 720p, then restart with another offer in the same cycle
        set_cfg(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        step(1);
        chk("p720_pending", pending, 1);
        chk("p720_ready_low", ready, 0);
        chk("p720_sx_unchanged", sx, -139);
        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b0);
        restart = 1'b1;
        #1;
        chk("restart_ready_forced", ready, 0);
        step(1);
        restart = 1'b0;
        cfg_valid = 1'b0;
        chk("restart_sx", sx, -370);
        chk("restart_sy", sy, -30);
        chk("restart_pending", pending, 0);
        chk("restart_frame", frame, 1);
        chk("restart_hs", hs, 0);
        chk("restart_vs", vs, 0);
        chk("restart_err", err, 0);
        step(109);
        chk("p720_hs_pre", hs, 0);
        step(1);
        chk("p720_sx_ss", sx, -260);
        chk("p720_hs_on", hs, 1);
        step(39);
        chk("p720_hs_last", hs, 1);
        step(1);
        chk("p720_hs_off", hs, 0);
        chk("p720_sx_se", sx, -220);

        // Tiny mode 8/2/3/1 x 4/1/2/1: 14-pixel lines, 8 lines, 112-cycle frame
        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b0);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk("tiny_pending", pending, 1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("tiny_sx", sx, -6);
        chk("tiny_sy", sy, -4);
        chk("tiny_hs", hs, 0);
        chk("tiny_vs", vs, 1);
        n_frame = 0; n_line = 0; n_de = 0; n_hs = 0; n_vs_low = 0;
        min_sx = 1000; max_sx = -1000;
        for (int i = 0; i < 112; i++) begin
            step(1);
            n_frame  += int'(frame);
            n_line   += int'(line);
            n_de     += int'(de);
            n_hs     += int'(hs);
            n_vs_low += int'(!vs);
            if (sx < min_sx) min_sx = sx;
            if (sx > max_sx) max_sx = sx;
        end
        chk("tiny_frames", n_frame, 1);
        chk("tiny_lines", n_line, 8);
        chk("tiny_de", n_de, 32);
        chk("tiny_hs_high", n_hs, 24);
        chk("tiny_vs_low", n_vs_low, 28);
        chk("tiny_min_sx", min_sx, -6);
        chk("tiny_max_sx", max_sx, 7);
        chk("tiny_frame_end", frame, 1);

        // Handshake on the wrap cycle: old timing for one more frame
        step(111);
        chk("wrap_sx", sx, 7);
        chk("wrap_sy", sy, 3);
        set_cfg(4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        #1;
        chk("wrap_ready", ready, 1);
        step(1);
        cfg_valid = 1'b0;
        chk("wrap_old_sx", sx, -6);
        chk("wrap_old_sy", sy, -4);
        chk("wrap_pending", pending, 1);
        step(111);
        chk("wrap2_sx", sx, 7);
        chk("wrap2_pending", pending, 1);
        step(1);
        chk("newcfg_sx", sx, -3);
        chk("newcfg_sy", sy, -3);
        chk("newcfg_pending", pending, 0);
        chk("newcfg_frame", frame, 1);
        chk("newcfg_hs", hs, 1);
        step(1);
        chk("newcfg_hs_on", hs, 0);
        step(33);
        chk("newcfg_frame_mid", frame, 0);
        step(1);
        chk("newcfg_frame_again", frame, 1);
        chk("newcfg_sx_again", sx, -3);

        // Async reset while a config is staged
        set_cfg(8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b0);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        chk("arst_pre_pending", pending, 1);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sx", sx, -160);
        chk("arst_sy", sy, -45);
        chk("arst_pending", pending, 0);
        chk("arst_ready", ready, 1);
        chk("arst_err", err, 0);
        chk("arst_de", de, 0);
        chk("arst_frame", frame, 1);
        chk("arst_hs", hs, 1);
        #2;
        rst_n = 1'b1;
        step(1);
        chk("arst_after_err", err, 0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("arst_restart_sx", sx, -160);
        chk("arst_restart_sy", sy, -45);
        step(16);
        chk("arst_def_hs", hs, 0);
        chk("arst_def_sx", sx, -144);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_timings_prog.md
Name: display_timings_prog

Overview:
- Runtime-programmable successor to the fixed 640x480 timing generator: same signed beam-position scheme (active area at sx,sy >= 0, blanking negative), but all timing values and sync polarities are loaded at run time through a valid/ready config port.
- A new config takes effect only at a frame boundary, so the display never sees a torn frame.
- Sits between the pixel-clock MMCM and the TMDS/HDMI encoder; lets the Mac capture path switch modes without a re-synthesis.

Parameters:
- CORDW, 16, width of signed o_sx/o_sy and of every config field (fields are unsigned CORDW-1 bits).
- D_H_RES, 640, reset-default horizontal active pixels.
- D_H_FP / D_H_SYNC / D_H_BP, 16 / 96 / 48, reset-default horizontal porches and sync.
- D_V_RES, 480, reset-default active lines.
- D_V_FP / D_V_SYNC / D_V_BP, 10 / 2 / 33, reset-default vertical porches and sync.
- D_H_POL / D_V_POL, 0 / 0, reset-default sync polarity (0 = negative, 1 = positive).

Ports:
- i_pix_clk  in  1  pixel clock; only clock in the block.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_restart  in  1  synchronous: jump to frame start next cycle.
- i_cfg_valid  in  1  config offer.
- o_cfg_ready  out  1  config can be accepted.
- i_cfg_h_res, i_cfg_h_fp, i_cfg_h_sync, i_cfg_h_bp  in  CORDW-1 each  horizontal timing.
- i_cfg_v_res, i_cfg_v_fp, i_cfg_v_sync, i_cfg_v_bp  in  CORDW-1 each  vertical timing.
- i_cfg_h_pol, i_cfg_v_pol  in  1 each  sync polarities.
- o_cfg_pending  out  1  accepted config waiting for the frame boundary.
- o_cfg_err  out  1  one-cycle pulse: offered config rejected.
- o_hs, o_vs  out  1 each  syncs, polarity applied.
- o_de  out  1  active video.
- o_frame  out  1  one tick at the first blanking pixel of a frame.
- o_line  out  1  one tick at the first blanking pixel of each line.
- o_sx, o_sy  out  signed CORDW  beam position, including blanking.

Behaviour:
- Derived values per axis, from the active config: STA = -(fp+sync+bp); SS = STA+fp; SE = SS+sync; active end = res-1.
- Counting: o_sx steps from H_STA to H_RES-1, then wraps to H_STA. o_sy increments on each horizontal wrap, from V_STA to V_RES-1, then wraps to V_STA.
- Sync decode: sync asserted for SS <= pos < SE (exactly `sync` pixels or lines). o_hs = h_pol ? in_sync : ~in_sync; o_vs likewise.
- Flags o_de (sx>=0 && sy>=0), o_frame (sx==H_STA && sy==V_STA) and o_line (sx==H_STA) are registered, computed from the next-state counters. They are cycle-aligned with o_sx/o_sy, with zero added latency.
- Reset (i_rst_n low, async): active config = D_* parameters; o_sx = D_H_STA; o_sy = D_V_STA; pending = 0; o_cfg_ready = 1; o_cfg_err = 0; o_frame = 1; o_line = 1; o_de = 0; o_hs/o_vs at their inactive levels.
- Config handshake: transfer when i_cfg_valid && o_cfg_ready. o_cfg_ready = ~pending.
  - Valid config: latched into a shadow register, pending <= 1.
  - Invalid config: dropped; o_cfg_err pulses on the next cycle; pending stays 0.
- Invalid config means any of: h_res, v_res, h_sync or v_sync is zero; fp+sync+bp overflows CORDW-1 bits on either axis.
- Apply point: the cycle where sx==H_RES-1 && sy==V_RES-1 (frame wrap). If pending, load the shadow into the active config, pending <= 0, and wrap counters to the new STA values. Otherwise wrap with the current config.
- Simultaneous handshake and frame wrap: the wrap uses the old config. The new config becomes pending and applies at the following wrap.
- i_restart: counters go to STA of the pending config if pending, else of the active config; the pending config is applied and pending clears. i_restart overrides a same-cycle handshake (handshake ignored, o_cfg_ready forced low that cycle).
- Async reset mid-line or mid-handshake: the shadow config is discarded; no error pulse is issued.
- Arithmetic: all position compares are signed CORDW. Config fields are zero-extended before negation.

Decomposition:
- Package display_timings_pkg:
  - CORDW default.
  - Packed struct timing_cfg_t (res/fp/sync/bp per axis, pols).
  - localparam TIMING_640x480 and TIMING_1280x720 presets.
  - Function cfg_valid(timing_cfg_t).
- Sub-module timing_axis: one axis counter with STA/end/sync decode, an advance enable and a wrap output. Instantiated twice; the V instance is enabled by the H wrap.

Test Plan:
- Reset with defaults -> o_frame interval is 420000 cycles; o_hs low for 96 consecutive cycles per 800-cycle line; o_de high for 640x480 pixels per frame.
- Mid-frame load of 1280x720 (110/40/220, 5/5/20, pol 1/1) -> o_cfg_pending=1 until the wrap, frame N unchanged.
  - From the next frame: o_frame interval 1237500; o_hs high for 40 cycles per line; o_sx min -370.
- Config with h_res=0 -> o_cfg_err is a single pulse one cycle after the handshake, o_cfg_ready stays 1, timing unchanged.
- Handshake exactly on the wrap cycle (sx=639, sy=479) -> the next frame is still 640x480; the 720p config applies one frame later.
- i_restart with a config pending -> next cycle o_sx=-370, o_sy=-30, pending=0; a handshake offered in the same cycle is not accepted.
- Async i_rst_n pulse mid-line while pending -> outputs immediately go to their reset values, config returns to 640x480, pending=0.
